// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA command sequencer.
// The ULA op code is {mode, oper}: mode 0 selects arithmetic, mode 1 selects logic.
package ula_pkg;

    localparam int WIDTH = 6;
    localparam int NREGS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    // Arithmetic group (mode = 0); the ULA reports carry/borrow on overflow
    localparam logic [3:0] OP_ADD   = 4'b0000;  // A + B
    localparam logic [3:0] OP_SUB   = 4'b0001;  // A - B
    localparam logic [3:0] OP_SUBR  = 4'b0010;  // B - A
    localparam logic [3:0] OP_DECA  = 4'b0011;  // A - 1
    localparam logic [3:0] OP_INCA  = 4'b0100;  // A + 1
    localparam logic [3:0] OP_INCB  = 4'b0101;  // B + 1
    localparam logic [3:0] OP_DECB  = 4'b0110;  // B - 1
    localparam logic [3:0] OP_NEGA  = 4'b0111;  // 0 - A

    // Logic group (mode = 1); overflow is left untouched by the ULA
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_NAND  = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1011;
    localparam logic [3:0] OP_XOR   = 4'b1100;
    localparam logic [3:0] OP_XNOR  = 4'b1101;
    localparam logic [3:0] OP_PASSA = 4'b1110;
    localparam logic [3:0] OP_PASSB = 4'b1111;

endpackage

// File: rtl/ula_regfile.sv
// Operand register file: NREGS x WIDTH, two combinational read ports,
// one clocked write port, synchronous clear on reset.
module ula_regfile
    import ula_pkg::*;
#(
    parameter int WIDTH = ula_pkg::WIDTH,
    parameter int NREGS = ula_pkg::NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] regs_q [NREGS];

    // Storage: cleared by reset, single write per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/ula_sequencer.sv
// Command-driven initiator for one external ULA instance.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | ready for a command; operands sampled from RF on accept
//   CLEAR | ULA held in reset with operands/op driven (clears overflow)
//   ISSUE | ULA released; result and flags captured at end of cycle
//   RESP  | response valid, held stable until rsp_ready
//
// The ULA is kept in reset whenever it is not in ISSUE, so a stale overflow
// from an earlier command can never leak into a logic op's flags.
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int WIDTH = ula_pkg::WIDTH,
    parameter int NREGS = ula_pkg::NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic             ovf_sticky,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_mode,
    output logic [2:0]       alu_oper,
    output logic             alu_reset,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_overflow,
    input  logic             alu_zero
);

    seq_state_t       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_reset_q;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_valid_q;
    logic             ovf_sticky_q, ovf_sticky_d;

    logic             cmd_fire;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rf_rdata_a;
    logic [WIDTH-1:0] rf_rdata_b;

    ula_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (cmd_ra),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (cmd_rb),
        .rdata_b_o (rf_rdata_b)
    );

    // Ready is the only unregistered output; it drops while reset is asserted
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Next-state, operand/response capture and RF write selection
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_data_d = rsp_data_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_zero_d = rsp_zero_q;
        rf_we      = 1'b0;
        rf_waddr   = rd_q;
        rf_wdata   = alu_o;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    alu_a_d = rf_rdata_a;
                    alu_b_d = rf_rdata_b;
                    if (cmd_load) begin
                        rf_we      = 1'b1;
                        rf_waddr   = cmd_rd;
                        rf_wdata   = cmd_imm;
                        rsp_data_d = cmd_imm;
                        rsp_ovf_d  = 1'b0;
                        rsp_zero_d = (cmd_imm == '0);
                        state_d    = RESP;
                    end else begin
                        state_d    = CLEAR;
                    end
                end
            end
            CLEAR: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                rf_we      = 1'b1;
                rsp_data_d = alu_o;
                rsp_ovf_d  = alu_overflow;
                rsp_zero_d = alu_zero;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ovf_sticky_d = ovf_sticky_q;
        if ((state_d == RESP) && (state_q != RESP)) begin
            ovf_sticky_d = ovf_sticky_q | rsp_ovf_d;
        end
    end

    // State and registered outputs; reset aborts any in-flight command
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_reset_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_reset_q  <= (state_d != ISSUE);
            rsp_data_q   <= rsp_data_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_valid_q  <= (state_d == RESP);
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_zero   = rsp_zero_q;
    assign ovf_sticky = ovf_sticky_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_mode   = op_q[3];
    assign alu_oper   = op_q[2:0];
    assign alu_reset  = alu_reset_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer with a behavioural 6-bit ULA attached.
// The ULA holds its overflow across logic ops until reset, so flag
// clearing between commands is observable.
module tb_ula_sequencer;
    import ula_pkg::*;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_load;
    logic [3:0]   cmd_op;
    logic [1:0]   cmd_rd, cmd_ra, cmd_rb;
    logic [W-1:0] cmd_imm;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf, rsp_zero, ovf_sticky;
    logic [W-1:0] alu_a, alu_b;
    logic         alu_mode;
    logic [2:0]   alu_oper;
    logic         alu_reset;
    logic [W-1:0] alu_o;
    logic         alu_overflow, alu_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ula_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_load     (cmd_load),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_ra       (cmd_ra),
        .cmd_rb       (cmd_rb),
        .cmd_imm      (cmd_imm),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_ovf      (rsp_ovf),
        .rsp_zero     (rsp_zero),
        .ovf_sticky   (ovf_sticky),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_mode     (alu_mode),
        .alu_oper     (alu_oper),
        .alu_reset    (alu_reset),
        .alu_o        (alu_o),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero)
    );

    // Behavioural ULA: bit W of ula_res is carry/borrow for arithmetic ops
    logic [W:0] ula_res;
    logic       ula_ovf_q;

    always_comb begin
        ula_res = '0;
        case ({alu_mode, alu_oper})
            OP_ADD:   ula_res = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:   ula_res = {1'b0, alu_a} - {1'b0, alu_b};
            OP_SUBR:  ula_res = {1'b0, alu_b} - {1'b0, alu_a};
            OP_DECA:  ula_res = {1'b0, alu_a} - 7'd1;
            OP_INCA:  ula_res = {1'b0, alu_a} + 7'd1;
            OP_INCB:  ula_res = {1'b0, alu_b} + 7'd1;
            OP_DECB:  ula_res = {1'b0, alu_b} - 7'd1;
            OP_NEGA:  ula_res = 7'd0 - {1'b0, alu_a};
            OP_AND:   ula_res = {1'b0, alu_a & alu_b};
            OP_OR:    ula_res = {1'b0, alu_a | alu_b};
            OP_NAND:  ula_res = {1'b0, ~(alu_a & alu_b)};
            OP_NOR:   ula_res = {1'b0, ~(alu_a | alu_b)};
            OP_XOR:   ula_res = {1'b0, alu_a ^ alu_b};
            OP_XNOR:  ula_res = {1'b0, ~(alu_a ^ alu_b)};
            OP_PASSA: ula_res = {1'b0, alu_a};
            OP_PASSB: ula_res = {1'b0, alu_b};
            default:  ula_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (alu_reset) ula_ovf_q <= 1'b0;
        else if (!alu_mode) ula_ovf_q <= ula_res[W];
    end

    assign alu_o        = ula_res[W-1:0];
    assign alu_overflow = alu_mode ? ula_ovf_q : ula_res[W];
    assign alu_zero     = (alu_o == '0);

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command, wait for its response, optionally stall, then consume it
    task automatic exec(input string tag, input logic ld, input logic [3:0] op,
                        input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [W-1:0] imm, input int e_data, input int e_ovf,
                        input int e_zero, input int stall);
        int lat;
        logic [W-1:0] d0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op;
        cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        lat = 0;
        while (!cmd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/accept"}, int'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ld && lat == 1) check({tag, "/alu_reset_clear"}, int'(alu_reset), 1);
            if (!ld && lat == 2) check({tag, "/alu_reset_issue"}, int'(alu_reset), 0);
            if (lat < 3) check({tag, "/busy_ready"}, int'(cmd_ready), 0);
        end while (!rsp_valid && lat < 20);
        check({tag, "/latency"}, lat, ld ? 1 : 3);
        check({tag, "/data"}, int'(rsp_data), e_data);
        check({tag, "/ovf"}, int'(rsp_ovf), e_ovf);
        check({tag, "/zero"}, int'(rsp_zero), e_zero);
        d0 = rsp_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "/stall_valid"}, int'(rsp_valid), 1);
            check({tag, "/stall_data"}, int'(rsp_data), int'(d0));
            check({tag, "/stall_ovf"}, int'(rsp_ovf), e_ovf);
            check({tag, "/stall_ready"}, int'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "/back_idle"}, int'(cmd_ready), 1);
        check({tag, "/rsp_drop"}, int'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0;
        cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/cmd_ready", int'(cmd_ready), 0);
        check("rst/alu_reset", int'(alu_reset), 1);
        check("rst/rsp_valid", int'(rsp_valid), 0);
        check("rst/ovf_sticky", int'(ovf_sticky), 0);
        check("rst/alu_a", int'(alu_a), 0);
        check("rst/rsp_data", int'(rsp_data), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst/ready_after", int'(cmd_ready), 1);

        // Add with carry out, then a logic op that must see a cleared overflow
        exec("ld_r0_63", 1'b1, 4'b0, 2'd0, 2'd0, 2'd0, 6'd63, 63, 0, 0, 0);
        exec("ld_r1_1",  1'b1, 4'b0, 2'd1, 2'd0, 2'd0, 6'd1,  1,  0, 0, 0);
        exec("add_ovf",  1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 6'd0, 0, 1, 1, 0);
        check("add_ovf/sticky", int'(ovf_sticky), 1);
        exec("and_clr",  1'b0, OP_AND, 2'd2, 2'd0, 2'd1, 6'd0, 1, 0, 0, 0);
        check("and_clr/sticky", int'(ovf_sticky), 1);
        exec("ld_zero",  1'b1, 4'b0, 2'd0, 2'd0, 2'd0, 6'd0, 0, 0, 1, 0);

        // Subtract with borrow
        exec("ld_r0_5",  1'b1, 4'b0, 2'd0, 2'd0, 2'd0, 6'd5, 5, 0, 0, 0);
        exec("ld_r1_7",  1'b1, 4'b0, 2'd1, 2'd0, 2'd0, 6'd7, 7, 0, 0, 0);
        exec("sub_brw",  1'b0, OP_SUB, 2'd2, 2'd0, 2'd1, 6'd0, 62, 1, 0, 0);

        // Back-pressure on an XOR, then pass-through of A
        exec("xor_stall", 1'b0, OP_XOR,   2'd3, 2'd0, 2'd1, 6'd0, 2, 0, 0, 3);
        exec("passa",     1'b0, OP_PASSA, 2'd2, 2'd0, 2'd1, 6'd0, 5, 0, 0, 0);

        // Destination aliases the source: old operand is used each time
        exec("ld_r3_10", 1'b1, 4'b0,    2'd3, 2'd0, 2'd0, 6'd10, 10, 0, 0, 0);
        exec("inc_1",    1'b0, OP_INCA, 2'd3, 2'd3, 2'd3, 6'd0,  11, 0, 0, 0);
        exec("inc_2",    1'b0, OP_INCA, 2'd3, 2'd3, 2'd3, 6'd0,  12, 0, 0, 0);

        // Reset while the command is in ISSUE: aborted, RF cleared
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD;
        cmd_rd = 2'd1; cmd_ra = 2'd3; cmd_rb = 2'd3;
        check("rstiss/accept", int'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstiss/in_issue", int'(alu_reset), 0);
        reset = 1'b1;
        #1 check("rstiss/ready_in_reset", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        check("rstiss/alu_reset", int'(alu_reset), 1);
        check("rstiss/rsp_valid", int'(rsp_valid), 0);
        check("rstiss/sticky", int'(ovf_sticky), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstiss/no_rsp", int'(rsp_valid), 0);
            check("rstiss/ready", int'(cmd_ready), 1);
        end
        exec("rf0_zero", 1'b0, OP_PASSA, 2'd0, 2'd0, 2'd0, 6'd0, 0, 0, 1, 0);
        exec("rf1_zero", 1'b0, OP_PASSA, 2'd0, 2'd1, 2'd0, 6'd0, 0, 0, 1, 0);
        exec("rf2_zero", 1'b0, OP_PASSA, 2'd0, 2'd2, 2'd0, 6'd0, 0, 0, 1, 0);
        exec("rf3_zero", 1'b0, OP_PASSB, 2'd0, 2'd0, 2'd3, 6'd0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
